// File: rtl/rib_xbar_rr_if.sv
// Bus bundle for rib_xbar_rr. The master modport is the environment view (requesters plus slave read data);
// the slave modport is the crossbar's view.
interface rib_xbar_rr_if #(
    parameter int NUM_M  = 4,
    parameter int NUM_S  = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_M-1:0]        m_req_i;
    logic [NUM_M-1:0]        m_we_i;
    logic [NUM_M*ADDR_W-1:0] m_addr_i;
    logic [NUM_M*DATA_W-1:0] m_data_i;
    logic [NUM_M*DATA_W-1:0] m_data_o;
    logic [NUM_M-1:0]        m_gnt_o;
    logic [NUM_M-1:0]        m_hold_o;
    logic [ADDR_W-1:0]       s_addr_o;
    logic [DATA_W-1:0]       s_data_o;
    logic [NUM_S-1:0]        s_we_o;
    logic [NUM_S*DATA_W-1:0] s_data_i;
    logic                    dec_err_o;

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
        input  m_data_o, m_gnt_o, m_hold_o, s_addr_o, s_data_o, s_we_o, dec_err_o
    );

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
        output m_data_o, m_gnt_o, m_hold_o, s_addr_o, s_data_o, s_we_o, dec_err_o
    );
endinterface

// File: rtl/rib_xbar_rr.sv
// N-master to M-slave RIB crossbar with round-robin arbitration, bounded ownership and address decode.
// Optional decode-error capture log enabled by defining RIB_DECERR_LOG_EN.
module rib_xbar_rr #(
    parameter int NUM_M    = 4,
    parameter int NUM_S    = 6,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef RIB_DECERR_LOG_EN
    input  logic                     err_clr_i,
    output logic                     err_vld_o,
    output logic [$clog2(NUM_M)-1:0] err_mst_o,
    output logic [ADDR_W-1:0]        err_addr_o,
`endif
    rib_xbar_rr_if.slave             bus
);
    localparam int OW = $clog2(NUM_M);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1'b1);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{SEL_W{1'b0}}, {(ADDR_W-SEL_W){1'b1}}};

    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic          owned_q, owned_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NUM_M-1:0]        req_s;
    logic [NUM_M-1:0]        gnt_s;
    logic [OW:0]             pick_s;
    logic [OW-1:0]           gidx_s;
    logic                    gvld_s;
    logic                    others_s;
    logic                    lock_s;
    logic [ADDR_W-1:0]       gaddr_s;
    logic [SEL_W-1:0]        sel_s;
    logic [NUM_S-1:0]        hit_s;
    logic [NUM_S-1:0]        swe_s;
    logic [DATA_W-1:0]       rd_s;
    logic [NUM_M*DATA_W-1:0] mdata_s;
    logic                    dec_err_s;

    // First requester at or after start, wrapping; result is {found, index}.
    function automatic logic [OW:0] rr_pick(input logic [NUM_M-1:0] req, input logic [OW-1:0] start);
        logic [OW:0] res;
        int          c;
        res = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            c = (int'(start) + k) % NUM_M;
            if (req[c]) begin
                res = {1'b1, OW'(c)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Reset masks every request so all grant-derived outputs read zero while rst is high
    assign req_s = rst ? '0 : bus.m_req_i;

    // Arbitration: keep the current owner while its run is open, else round-robin scan
    always_comb begin
        others_s = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            others_s = others_s | (req_s[i] & (OW'(i) != owner_q));
        end
        lock_s = owned_q & req_s[owner_q] & ((int'(cnt_q) < (MAX_HOLD - 32'sd1)) | ~others_s);
        pick_s = rr_pick(req_s, ptr_q);
        if (lock_s) begin
            gidx_s = owner_q;
            gvld_s = 1'b1;
        end else begin
            gidx_s = pick_s[OW-1:0];
            gvld_s = pick_s[OW];
        end
        gnt_s = '0;
        for (int i = 0; i < NUM_M; i++) begin
            gnt_s[i] = gvld_s & (gidx_s == OW'(i));
        end
    end

    // Decode the granted address and route write strobe and read data
    always_comb begin
        gaddr_s = bus.m_addr_i[int'(gidx_s)*ADDR_W +: ADDR_W];
        sel_s   = gaddr_s[ADDR_W-1 -: SEL_W];
        rd_s    = '0;
        hit_s   = '0;
        swe_s   = '0;
        for (int j = 0; j < NUM_S; j++) begin
            hit_s[j] = gvld_s & (sel_s == SEL_W'(j));
            swe_s[j] = hit_s[j] & bus.m_we_i[gidx_s];
            rd_s     = rd_s | ({DATA_W{hit_s[j]}} & bus.s_data_i[j*DATA_W +: DATA_W]);
        end
        dec_err_s = gvld_s & (int'(sel_s) >= NUM_S);
        mdata_s   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            mdata_s[i*DATA_W +: DATA_W] = {DATA_W{gnt_s[i]}} & rd_s;
        end
    end

    assign bus.m_gnt_o   = gnt_s;
    assign bus.m_hold_o  = req_s & ~gnt_s;
    assign bus.s_we_o    = swe_s;
    assign bus.dec_err_o = dec_err_s;
    assign bus.m_data_o  = mdata_s;
    assign bus.s_addr_o  = gvld_s ? (gaddr_s & OFF_MASK) : '0;
    assign bus.s_data_o  = gvld_s ? bus.m_data_i[int'(gidx_s)*DATA_W +: DATA_W] : '0;

    // Next state: a new owner restarts its run and moves the scan start just past itself
    always_comb begin
        owned_d = |req_s;
        owner_d = owner_q;
        cnt_d   = '0;
        ptr_d   = ptr_q;
        if (gvld_s) begin
            owner_d = gidx_s;
            if (owned_q && (gidx_s == owner_q)) begin
                cnt_d = others_s ? (cnt_q + CNT_ONE) : '0;
            end else begin
                ptr_d = OW'((int'(gidx_s) + 32'sd1) % NUM_M);
            end
        end else begin
            owner_d = owner_q;
        end
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            owned_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            owner_q <= owner_d;
            owned_q <= owned_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RIB_DECERR_LOG_EN
    logic              err_vld_q, err_vld_d;
    logic [OW-1:0]     err_mst_q, err_mst_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Capture only the first error; a clear in the same cycle as a new error re-arms and captures it
    always_comb begin
        err_vld_d  = err_vld_q;
        err_mst_d  = err_mst_q;
        err_addr_d = err_addr_q;
        if (dec_err_s && (!err_vld_q || err_clr_i)) begin
            err_vld_d  = 1'b1;
            err_mst_d  = gidx_s;
            err_addr_d = gaddr_s;
        end else if (err_clr_i) begin
            err_vld_d  = 1'b0;
            err_mst_d  = '0;
            err_addr_d = '0;
        end else begin
            err_vld_d  = err_vld_q;
        end
    end

    // Error log register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld_q  <= 1'b0;
            err_mst_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_vld_q  <= err_vld_d;
            err_mst_q  <= err_mst_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_vld_o  = err_vld_q;
    assign err_mst_o  = err_mst_q;
    assign err_addr_o = err_addr_q;
`endif
endmodule

// File: tb/tb_rib_xbar_rr.sv
// Bench for rib_xbar_rr: two instances (MAX_HOLD=8 and MAX_HOLD=1) share stimulus and are checked
// against a behavioural model, plus a directed vector table. Log checks apply when RIB_DECERR_LOG_EN is defined.
module tb_rib_xbar_rr;
    localparam int NM = 4;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [191:0] sdata;
    logic         err_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    rib_xbar_rr_if #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) bus8 ();
    rib_xbar_rr_if #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus8.m_req_i  = req;
    assign bus8.m_we_i   = we;
    assign bus8.m_addr_i = addr;
    assign bus8.m_data_i = wdata;
    assign bus8.s_data_i = sdata;
    assign bus1.m_req_i  = req;
    assign bus1.m_we_i   = we;
    assign bus1.m_addr_i = addr;
    assign bus1.m_data_i = wdata;
    assign bus1.s_data_i = sdata;

`ifdef RIB_DECERR_LOG_EN
    logic        ev8, ev1;
    logic [1:0]  em8, em1;
    logic [31:0] ea8, ea1;
`endif

    rib_xbar_rr #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .MAX_HOLD(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
`ifdef RIB_DECERR_LOG_EN
        .err_clr_i  (err_clr),
        .err_vld_o  (ev8),
        .err_mst_o  (em8),
        .err_addr_o (ea8),
`endif
        .bus        (bus8.slave)
    );

    rib_xbar_rr #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .MAX_HOLD(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
`ifdef RIB_DECERR_LOG_EN
        .err_clr_i  (err_clr),
        .err_vld_o  (ev1),
        .err_mst_o  (em1),
        .err_addr_o (ea1),
`endif
        .bus        (bus1.slave)
    );

    // ---------------- behavioural model (index 0: MAX_HOLD=8, index 1: MAX_HOLD=1)
    int          mh      [2];
    int          m_owner [2];
    int          m_run   [2];
    int          m_start [2];
    bit          lv      [2];
    int          lm      [2];
    logic [31:0] la      [2];

    function automatic bit others_than(int o);
        for (int i = 0; i < NM; i++) begin
            if (i != o && req[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_grant(int d);
        if (rst || req == 4'b0000) return -1;
        if (m_owner[d] >= 0 && req[m_owner[d]] &&
            (m_run[d] < mh[d] - 1 || !others_than(m_owner[d]))) return m_owner[d];
        for (int k = 0; k < NM; k++) begin
            int c = (m_start[d] + k) % NM;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(string nm, int d, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, act, exp);
    endtask

    task automatic check_dut(int d, logic [3:0] gnt, logic [3:0] hold, logic [31:0] sa,
                             logic [31:0] sd, logic [5:0] swe, logic err, logic [127:0] md);
        int           g;
        int           idx;
        logic [31:0]  a;
        logic [3:0]   eg, eh;
        logic [31:0]  esa, esd;
        logic [5:0]   eswe;
        logic         ee;
        logic [127:0] emd;
        g = exp_grant(d);
        eg = '0; eh = '0; esa = '0; esd = '0; eswe = '0; ee = 1'b0; emd = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            a     = addr[g*32 +: 32];
            idx   = int'(a[31:28]);
            esa   = a & 32'h0FFF_FFFF;
            esd   = wdata[g*32 +: 32];
            if (idx < NS) begin
                eswe[idx]       = we[g];
                emd[g*32 +: 32] = sdata[idx*32 +: 32];
            end else begin
                ee = 1'b1;
            end
        end
        if (!rst) eh = req & ~eg;
        chk("gnt", d, gnt, eg);
        chk("hold", d, hold, eh);
        chk("s_addr", d, sa, esa);
        chk("s_data", d, sd, esd);
        chk("s_we", d, swe, eswe);
        chk("dec_err", d, err, ee);
        chk("m_data", d, md, emd);
    endtask

    task automatic check_all();
        check_dut(0, bus8.m_gnt_o, bus8.m_hold_o, bus8.s_addr_o, bus8.s_data_o, bus8.s_we_o,
                  bus8.dec_err_o, bus8.m_data_o);
        check_dut(1, bus1.m_gnt_o, bus1.m_hold_o, bus1.s_addr_o, bus1.s_data_o, bus1.s_we_o,
                  bus1.dec_err_o, bus1.m_data_o);
`ifdef RIB_DECERR_LOG_EN
        chk("err_vld", 0, ev8, lv[0]);
        chk("err_vld", 1, ev1, lv[1]);
        if (lv[0]) begin
            chk("err_mst", 0, em8, lm[0]);
            chk("err_addr", 0, ea8, la[0]);
        end
        if (lv[1]) begin
            chk("err_mst", 1, em1, lm[1]);
            chk("err_addr", 1, ea1, la[1]);
        end
`endif
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            int g = exp_grant(d);
            if (rst) begin
                m_owner[d] = -1; m_run[d] = 0; m_start[d] = 0;
                lv[d] = 1'b0; lm[d] = 0; la[d] = '0;
            end else begin
                bit e = (g >= 0) && (int'(addr[g*32+28 +: 4]) >= NS);
                if (e && (!lv[d] || err_clr)) begin
                    lv[d] = 1'b1; lm[d] = g; la[d] = addr[g*32 +: 32];
                end else if (err_clr) begin
                    lv[d] = 1'b0;
                end
                if (g < 0) begin
                    m_owner[d] = -1; m_run[d] = 0;
                end else if (g == m_owner[d]) begin
                    m_run[d] = others_than(g) ? m_run[d] + 1 : 0;
                end else begin
                    m_owner[d] = g; m_run[d] = 0; m_start[d] = (g + 1) % NM;
                end
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        edge_step();
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] a0;
        logic [3:0]  g8;
        logic [3:0]  g1;
        logic [3:0]  hold8;
        logic [5:0]  swe8;
        logic        err8;
    } vec_t;

    vec_t tv[$];

    task automatic add(logic r, logic [3:0] rq, logic [3:0] w, logic [31:0] a0, logic [3:0] g8,
                       logic [3:0] g1, logic [3:0] h8, logic [5:0] swe, logic err);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.g8 = g8; v.g1 = g1;
        v.hold8 = h8; v.swe8 = swe; v.err8 = err;
        tv.push_back(v);
    endtask

    initial begin
        logic [3:0] g1seq [5];
        logic [3:0] g8v;
        g1seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mh = '{8, 1};
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_run[d] = 0; m_start[d] = 0; lv[d] = 1'b0; lm[d] = 0; la[d] = '0;
        end
        rst     = 1'b1;
        req     = 4'b0000;
        we      = 4'b0000;
        err_clr = 1'b0;
        addr    = {32'h4000_000C, 32'h3000_0008, 32'h2000_0004, 32'h1000_0000};
        wdata   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        sdata   = {32'hD000_0005, 32'hD000_0004, 32'hD000_0003, 32'hD000_0002,
                   32'hD000_0001, 32'hD000_0000};

        // reset with all requests, then release: 8-hold keeps m0, 1-hold rotates
        add(1'b1, 4'b1111, 4'b0000, 32'h1000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 1'b0);
        add(1'b1, 4'b1111, 4'b0000, 32'h1000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 1'b0);
        for (int k = 0; k < 5; k++)
            add(1'b0, 4'b1111, 4'b0000, 32'h1000_0000, 4'b0001, g1seq[k], 4'b1110, 6'b000000, 1'b0);
        add(1'b1, 4'b0000, 4'b0000, 32'h1000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 1'b0);
        // m0 and m2 contend: 8-cycle runs vs alternation
        for (int k = 0; k < 17; k++) begin
            g8v = (k < 8 || k == 16) ? 4'b0001 : 4'b0100;
            add(1'b0, 4'b0101, 4'b0000, 32'h1000_0000, g8v, (k % 2 == 0) ? 4'b0001 : 4'b0100,
                4'b0101 & ~g8v, 6'b000000, 1'b0);
        end
        // m1 alone: never dropped
        for (int k = 0; k < 20; k++)
            add(1'b0, 4'b0010, 4'b0000, 32'h1000_0000, 4'b0010, 4'b0010, 4'b0000, 6'b000000, 1'b0);
        // reset mid-ownership restarts from ptr 0
        add(1'b1, 4'b1111, 4'b0000, 32'h1000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 32'h1000_0000, 4'b0001, 4'b0001, 4'b1110, 6'b000000, 1'b0);
        // decode: valid write, out-of-range reads/writes, last valid slave
        add(1'b0, 4'b0001, 4'b0001, 32'h2000_0010, 4'b0001, 4'b0001, 4'b0000, 6'b000100, 1'b0);
        add(1'b0, 4'b0001, 4'b0000, 32'hF000_0000, 4'b0001, 4'b0001, 4'b0000, 6'b000000, 1'b1);
        add(1'b0, 4'b0001, 4'b0001, 32'h6000_0000, 4'b0001, 4'b0001, 4'b0000, 6'b000000, 1'b1);
        add(1'b0, 4'b0001, 4'b0001, 32'h5000_0000, 4'b0001, 4'b0001, 4'b0000, 6'b100000, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 32'h1000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 1'b0);

        foreach (tv[i]) begin
            rst        = tv[i].rst;
            req        = tv[i].req;
            we         = tv[i].we;
            addr[31:0] = tv[i].a0;
            @(negedge clk);
            check_all();
            chk("tbl_gnt8", 0, bus8.m_gnt_o, tv[i].g8);
            chk("tbl_gnt1", 1, bus1.m_gnt_o, tv[i].g1);
            chk("tbl_hold8", 0, bus8.m_hold_o, tv[i].hold8);
            chk("tbl_swe8", 0, bus8.s_we_o, tv[i].swe8);
            chk("tbl_err8", 0, bus8.dec_err_o, tv[i].err8);
            edge_step();
        end

`ifdef RIB_DECERR_LOG_EN
        // first bad access is kept, second ignored, clear pulse empties the log
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("log_pre_clr", 0, ev8, 1'b0);
        req = 4'b0001; we = 4'b0000; addr[31:0] = 32'hF000_0004; step();
        addr[31:0] = 32'hE000_0008; step();
        req = 4'b0000; step();
        chk("log_vld", 0, ev8, 1'b1);
        chk("log_addr", 0, ea8, 32'hF000_0004);
        chk("log_mst", 0, em8, 2'd0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("log_cleared", 0, ev8, 1'b0);
`endif

        // randomized traffic with sticky requests so ownership runs build up
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            we = 4'($urandom);
            for (int i = 0; i < NM; i++) begin
                addr[i*32 +: 32]  = $urandom;
                wdata[i*32 +: 32] = $urandom;
            end
            for (int j = 0; j < NS; j++) sdata[j*32 +: 32] = $urandom;
            err_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
